dct_blk_stream_adapter: RTL and testbench

Streaming front/back end for the 8x8 2-D DCT core's 64-word block handshake.
- Gathers LANES words per beat into a full 64-word block and presents it on the core's block-wide input handshake.
- Buffers up to two core output blocks (ping-pong) and serialises them LANES words per beat, in raster or JPEG zigzag order.
- Sits between the pixel/level-shift stream and the quantiser; the core is external and connected via the core_* ports.

---
 rtl/dct_blk_pkg.sv | 28 ++
 rtl/dct_blk_pingpong.sv | 110 +++++++++++
 rtl/dct_blk_stream_adapter.sv | 128 ++++++++++++
 tb/tb_dct_blk_stream_adapter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_blk_pkg.sv
// Shared constants and helpers for the DCT block stream adapter:
// block size, JPEG zigzag scan table and the beat-count helper.
package dct_blk_pkg;

    localparam int WORDS_PER_BLK = 64;

    // Zigzag scan: entry n is the raster index of the n-th coefficient in scan order.
    localparam int ZZ_ORDER [0:63] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic {
        ST_FILL    = 1'b0,
        ST_PRESENT = 1'b1
    } in_state_e;

    function automatic int beats_per_blk(input int lanes);
        return WORDS_PER_BLK / lanes;
    endfunction

endpackage

// File: rtl/dct_blk_pingpong.sv
// Two-entry result buffer between the DCT core and the output stream.
// Stores whole core result blocks and serialises the oldest one LANES
// words per beat, in raster or zigzag order chosen per block.
module dct_blk_pingpong
    import dct_blk_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_run,
    input  logic                              i_wr_valid,
    output logic                              o_wr_ready,
    input  logic [WORDS_PER_BLK*DATA_W-1:0]   i_wr_data,
    input  logic                              i_zz_en,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [LANES*DATA_W-1:0]           o_data,
    output logic                              o_last
);

    localparam int BEATS  = beats_per_blk(LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [DATA_W-1:0] r_buf [2][WORDS_PER_BLK];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic [BEAT_W-1:0] r_rd_beat;
    logic              r_mode;
    logic              r_mode_vld;

    logic w_wr;
    logic w_last_beat;
    logic w_free;
    logic w_mode;

    // Source word for a given output position: identity or zigzag lookup.
    function automatic logic [5:0] src_idx(input logic mode, input int pos);
        logic [5:0] p;
        p = 6'(pos);
        return mode ? 6'(ZZ_ORDER[p]) : p;
    endfunction

    // Acceptance depends only on the registered fill level, never on i_ready.
    assign o_wr_ready  = i_run && (r_count < 2'd2);
    assign w_wr        = i_wr_valid && o_wr_ready;
    assign o_valid     = (r_count != 2'd0);
    assign w_last_beat = (r_rd_beat == BEAT_W'(BEATS - 1));
    assign o_last      = o_valid && w_last_beat;
    assign w_free      = o_valid && i_ready && w_last_beat;
    // Until the mode is latched (first cycle beat 0 is shown) follow zz_en live.
    assign w_mode      = r_mode_vld ? r_mode : i_zz_en;

    // Capture a whole result block into the entry at the write pointer.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            for (int i = 0; i < WORDS_PER_BLK; i++) begin
                r_buf[r_wr_ptr][i] <= i_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer and occupancy bookkeeping; a write and a free together leave count unchanged.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_free) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_free};
        end
    end

    // Beat sequencing within the block at the read pointer, plus per-block order latch.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_beat  <= '0;
            r_mode     <= 1'b0;
            r_mode_vld <= 1'b0;
        end else begin
            if (o_valid && i_ready) begin
                r_rd_beat <= w_last_beat ? '0 : r_rd_beat + BEAT_W'(1);
            end
            if (w_free) begin
                r_mode_vld <= 1'b0;
            end else if (o_valid && !r_mode_vld) begin
                r_mode_vld <= 1'b1;
                r_mode     <= i_zz_en;
            end
        end
    end

    // Output beat: lane k carries the word at scan position beat*LANES+k.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < LANES; k++) begin
            o_data[k*DATA_W +: DATA_W] =
                r_buf[r_rd_ptr][src_idx(w_mode, int'(r_rd_beat) * LANES + k)];
        end
    end

endmodule

// File: rtl/dct_blk_stream_adapter.sv
// Stream adapter around the 8x8 DCT core: gathers LANES-wide input beats
// into a 64-word block for the core, checks producer framing, and hands
// core results to the ping-pong buffer for serialisation.
module dct_blk_stream_adapter
    import dct_blk_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [LANES*DATA_W-1:0]           s_data,
    input  logic                              s_last,
    output logic                              core_in_valid,
    input  logic                              core_in_ready,
    output logic [WORDS_PER_BLK*DATA_W-1:0]   core_in_data,
    input  logic                              core_out_valid,
    output logic                              core_out_ready,
    input  logic [WORDS_PER_BLK*DATA_W-1:0]   core_out_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [LANES*DATA_W-1:0]           m_data,
    output logic                              m_last,
    input  logic                              zz_en,
    output logic                              err_framing
);

    localparam int BEATS  = beats_per_blk(LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    in_state_e                r_state;
    in_state_e                w_state_nxt;
    logic [BEAT_W-1:0]        r_wr_beat;
    logic [LANES*DATA_W-1:0]  r_in_buf [2**BEAT_W];
    logic                     r_run;
    logic                     r_err;

    logic w_accept;
    logic w_blk_end;

    assign w_accept    = s_valid && s_ready;
    assign w_blk_end   = (r_wr_beat == BEAT_W'(BEATS - 1));
    assign err_framing = r_err;

    for (genvar b = 0; b < BEATS; b++) begin : g_core_in
        assign core_in_data[b*LANES*DATA_W +: LANES*DATA_W] = r_in_buf[b];
    end

    // Gather FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Gather FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        s_ready       = 1'b0;
        core_in_valid = 1'b0;
        case (r_state)
            ST_FILL: begin
                s_ready = r_run;
                if (r_run && s_valid && w_blk_end) begin
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                core_in_valid = 1'b1;
                if (core_in_ready) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Run flag holds both stream sides idle for the reset cycle itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Beat counter and framing check; block boundaries follow the count, not s_last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_beat <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && (s_last != w_blk_end);
            if (w_accept) begin
                r_wr_beat <= w_blk_end ? '0 : r_wr_beat + BEAT_W'(1);
            end
        end
    end

    // Store each accepted beat at its slot in the block under construction.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_in_buf[r_wr_beat] <= s_data;
        end
    end

    dct_blk_pingpong #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_pingpong (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_run      (r_run),
        .i_wr_valid (core_out_valid),
        .o_wr_ready (core_out_ready),
        .i_wr_data  (core_out_data),
        .i_zz_en    (zz_en),
        .o_valid    (m_valid),
        .i_ready    (m_ready),
        .o_data     (m_data),
        .o_last     (m_last)
    );

endmodule

// File: tb/tb_dct_blk_stream_adapter.sv
// Bench for dct_blk_stream_adapter: LANES=8 instance with a 3-cycle identity
// core model, plus LANES=1 and LANES=64 instances with a direct loopback core.
module tb_dct_blk_stream_adapter;

    localparam int DW = 32;
    localparam int L  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   npass = 0;
    int   ntot  = 0;
    int   cyc   = 0;

    // ---------------- main instance (LANES=8) ----------------
    logic              s_valid, s_ready, s_last;
    logic [L*DW-1:0]   s_data;
    logic              core_in_valid;
    logic              core_in_ready = 1'b1;
    logic [64*DW-1:0]  core_in_data;
    logic              core_out_valid = 1'b0;
    logic              core_out_ready;
    logic [64*DW-1:0]  core_out_data = '0;
    logic              m_valid, m_ready, m_last;
    logic [L*DW-1:0]   m_data;
    logic              zz_en, err_framing;

    dct_blk_stream_adapter #(.DATA_W(DW), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out_data(core_out_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .zz_en(zz_en), .err_framing(err_framing)
    );

    // ---------------- LANES=1 and LANES=64 instances, loopback core ----------------
    logic             a_s_valid, a_s_ready, a_s_last, a_civ, a_cir, a_cov, a_cor;
    logic [DW-1:0]    a_s_data, a_m_data;
    logic [64*DW-1:0] a_cid, a_cod;
    logic             a_m_valid, a_m_ready, a_m_last, a_zz, a_err;
    assign a_cir = a_cor;
    assign a_cov = a_civ;
    assign a_cod = a_cid;

    dct_blk_stream_adapter #(.DATA_W(DW), .LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
        .core_in_valid(a_civ), .core_in_ready(a_cir), .core_in_data(a_cid),
        .core_out_valid(a_cov), .core_out_ready(a_cor), .core_out_data(a_cod),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
        .zz_en(a_zz), .err_framing(a_err)
    );

    logic             b_s_valid, b_s_ready, b_s_last, b_civ, b_cir, b_cov, b_cor;
    logic [64*DW-1:0] b_s_data, b_m_data, b_cid, b_cod;
    logic             b_m_valid, b_m_ready, b_m_last, b_zz, b_err;
    assign b_cir = b_cor;
    assign b_cov = b_civ;
    assign b_cod = b_cid;

    dct_blk_stream_adapter #(.DATA_W(DW), .LANES(64)) dut_l64 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
        .core_in_valid(b_civ), .core_in_ready(b_cir), .core_in_data(b_cid),
        .core_out_valid(b_cov), .core_out_ready(b_cor), .core_out_data(b_cod),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
        .zz_en(b_zz), .err_framing(b_err)
    );

    // ---------------- identity core model, 3-cycle latency, one block in flight ----------------
    logic             cin_hs = 1'b0, cout_hs = 1'b0, core_busy = 1'b0;
    logic [64*DW-1:0] core_hold = '0;
    int               core_dly = 0;

    always @(negedge clk) begin
        cin_hs  = core_in_valid && core_in_ready;
        cout_hs = core_out_valid && core_out_ready;
        if (cin_hs) core_hold = core_in_data;
    end

    always begin
        @(posedge clk); #1;
        if (cout_hs) begin
            core_out_valid = 1'b0;
            core_busy      = 1'b0;
        end
        if (cin_hs) begin
            core_busy = 1'b1;
            core_dly  = 3;
        end else if (core_busy && !core_out_valid && core_dly > 0) begin
            core_dly--;
            if (core_dly == 0) begin
                core_out_valid = 1'b1;
                core_out_data  = core_hold;
            end
        end
        core_in_ready = !core_busy;
    end

    // ---------------- monitors (sampled mid-cycle, transfer occurs at next posedge) ----------------
    logic [DW-1:0] oq[$], qa[$], qb[$], exp_q[$], cur[$];
    bit            lq[$], la[$], lb[$];
    int            sq[$];
    int            err_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            for (int k = 0; k < L; k++) oq.push_back(m_data[k*DW +: DW]);
            lq.push_back(m_last);
            sq.push_back(cyc);
        end
        if (err_framing) err_cnt++;
        if (rst_n && a_m_valid && a_m_ready) begin
            qa.push_back(a_m_data);
            la.push_back(a_m_last);
        end
        if (rst_n && b_m_valid && b_m_ready) begin
            for (int k = 0; k < 64; k++) qb.push_back(b_m_data[k*DW +: DW]);
            lb.push_back(b_m_last);
        end
    end

    // ---------------- reference model ----------------
    // Raster index of the n-th element of the zigzag scan, by walking anti-diagonals.
    function automatic int zz_pos(input int n);
        int c;
        int r;
        c = 0;
        for (int s = 0; s < 15; s++) begin
            for (int j = 0; j < 8; j++) begin
                r = (s % 2 == 0) ? ((s < 8 ? s : 7) - j) : ((s < 8 ? 0 : s - 7) + j);
                if (r >= 0 && r < 8 && s - r >= 0 && s - r < 8) begin
                    if (c == n) return r * 8 + (s - r);
                    c++;
                end
            end
        end
        return 0;
    endfunction

    task automatic expect_block(input bit mode);
        for (int i = 0; i < 64; i++) exp_q.push_back(mode ? cur[zz_pos(i)] : cur[i]);
    endtask

    task automatic fill_ramp(input int offset);
        cur.delete();
        for (int i = 0; i < 64; i++) cur.push_back(DW'(i + offset));
    endtask

    task automatic fill_rand();
        cur.delete();
        for (int i = 0; i < 64; i++) cur.push_back($urandom);
    endtask

    task automatic clear_q();
        oq.delete(); lq.delete(); sq.delete(); exp_q.delete();
        err_cnt = 0;
    endtask

    task automatic send_block(input logic [7:0] lastmask);
        bit ok;
        for (int b = 0; b < 8; b++) begin
            s_valid = 1'b1;
            s_last  = lastmask[b[2:0]];
            for (int k = 0; k < L; k++) s_data[k*DW +: DW] = cur[b*L + k];
            ok = 1'b0;
            for (int n = 0; n < 300 && !ok; n++) begin
                @(negedge clk); ok = s_ready;
                @(posedge clk); #1;
            end
            if (!ok) begin
                ntot++;
                $display("FAIL send_block beat %0d: s_ready got 0, required 1", b);
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (oq.size() < n && t < 3000) begin @(posedge clk); #1; t++; end
        if (oq.size() < n) begin
            ntot++;
            $display("FAIL wait_out: got %0d words, required %0d", oq.size(), n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ntot++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b, required 0", s_ready); else npass++;
        ntot++; if (core_in_valid !== 1'b0) $display("FAIL rst_core_in_valid: got %b, required 0", core_in_valid); else npass++;
        ntot++; if (core_out_ready !== 1'b0) $display("FAIL rst_core_out_ready: got %b, required 0", core_out_ready); else npass++;
        ntot++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b, required 0", m_valid); else npass++;
        ntot++; if (m_last !== 1'b0) $display("FAIL rst_m_last: got %b, required 0", m_last); else npass++;
        ntot++; if (err_framing !== 1'b0) $display("FAIL rst_err_framing: got %b, required 0", err_framing); else npass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ntot++; if (s_ready !== 1'b1) $display("FAIL rel_s_ready: got %b, required 1", s_ready); else npass++;
        ntot++; if (core_out_ready !== 1'b1) $display("FAIL rel_core_out_ready: got %b, required 1", core_out_ready); else npass++;
    endtask

    task automatic test_raster();
        clear_q();
        zz_en = 1'b0; m_ready = 1'b1;
        for (int blk = 0; blk < 2; blk++) begin
            if (blk == 0) fill_ramp(0); else fill_rand();
            expect_block(1'b0);
            send_block(8'h80);
            ntot++; if (core_in_valid !== 1'b1) $display("FAIL raster_cin_latency: got %b, required 1", core_in_valid); else npass++;
            ntot++; if (s_ready !== 1'b0) $display("FAIL raster_s_ready_present: got %b, required 0", s_ready); else npass++;
        end
        wait_out(128);
        for (int i = 0; i < exp_q.size(); i++) begin
            ntot++;
            if (oq[i] !== exp_q[i]) $display("FAIL raster_word[%0d]: got %0h, required %0h", i, oq[i], exp_q[i]);
            else npass++;
        end
        for (int j = 0; j < 16; j++) begin
            ntot++;
            if (lq[j] !== (j % 8 == 7)) $display("FAIL raster_m_last[%0d]: got %b, required %b", j, lq[j], (j % 8 == 7));
            else npass++;
        end
        ntot++; if (err_cnt !== 0) $display("FAIL raster_err_framing: got %0d pulses, required 0", err_cnt); else npass++;
    endtask

    task automatic test_zigzag();
        int b0[$] = {0, 1, 8, 16, 9, 2, 3, 10};
        int b7[$] = {53, 60, 61, 54, 47, 55, 62, 63};
        logic [L*DW-1:0] d0;
        int t;
        clear_q();
        zz_en = 1'b1; m_ready = 1'b0;
        fill_ramp(0);
        expect_block(1'b1);
        send_block(8'h80);
        t = 0;
        while (!m_valid && t < 100) begin @(posedge clk); #1; t++; end
        ntot++; if (m_valid !== 1'b1) $display("FAIL zz_m_valid: got %b, required 1", m_valid); else npass++;
        @(posedge clk); #1;
        d0 = m_data;
        zz_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ntot++; if (m_data !== d0) $display("FAIL zz_hold_m_data: got %0h, required %0h", m_data, d0); else npass++;
        ntot++; if (m_last !== 1'b0) $display("FAIL zz_hold_m_last: got %b, required 0", m_last); else npass++;
        for (int k = 0; k < L; k++) begin
            ntot++;
            if (m_data[k*DW +: DW] !== DW'(b0[k])) $display("FAIL zz_beat0_lane%0d: got %0d, required %0d", k, m_data[k*DW +: DW], b0[k]);
            else npass++;
        end
        m_ready = 1'b1;
        wait_out(64);
        for (int k = 0; k < L; k++) begin
            ntot++;
            if (oq[56 + k] !== DW'(b7[k])) $display("FAIL zz_beat7_lane%0d: got %0d, required %0d", k, oq[56 + k], b7[k]);
            else npass++;
        end
        for (int i = 0; i < 64; i++) begin
            ntot++;
            if (oq[i] !== exp_q[i]) $display("FAIL zz_word[%0d]: got %0d, required %0d", i, oq[i], exp_q[i]);
            else npass++;
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        zz_en = 1'b0; m_ready = 1'b0;
        for (int blk = 0; blk < 3; blk++) begin
            fill_ramp(100 * blk);
            expect_block(1'b0);
            send_block(8'h80);
            ntot++; if (s_ready !== 1'b0) $display("FAIL b2b_s_ready_present%0d: got %b, required 0", blk, s_ready); else npass++;
        end
        repeat (10) @(posedge clk);
        #1;
        ntot++; if (core_out_ready !== 1'b0) $display("FAIL b2b_core_out_ready_full: got %b, required 0", core_out_ready); else npass++;
        ntot++; if (m_valid !== 1'b1) $display("FAIL b2b_m_valid_full: got %b, required 1", m_valid); else npass++;
        m_ready = 1'b1;
        wait_out(192);
        for (int i = 0; i < 192; i++) begin
            ntot++;
            if (oq[i] !== exp_q[i]) $display("FAIL b2b_word[%0d]: got %0d, required %0d", i, oq[i], exp_q[i]);
            else npass++;
        end
        for (int j = 1; j < 24; j++) begin
            ntot++;
            if (sq[j] !== sq[0] + j) $display("FAIL b2b_gap beat %0d: got cycle %0d, required %0d", j, sq[j], sq[0] + j);
            else npass++;
        end
    endtask

    task automatic test_framing();
        clear_q();
        zz_en = 1'b0; m_ready = 1'b1;
        fill_rand();
        expect_block(1'b0);
        send_block(8'h08);
        wait_out(64);
        ntot++; if (err_cnt !== 2) $display("FAIL framing_pulses: got %0d, required 2", err_cnt); else npass++;
        for (int i = 0; i < 64; i++) begin
            ntot++;
            if (oq[i] !== exp_q[i]) $display("FAIL framing_word[%0d]: got %0h, required %0h", i, oq[i], exp_q[i]);
            else npass++;
        end
    endtask

    task automatic test_reset_mid_drain();
        int t;
        clear_q();
        zz_en = 1'b0; m_ready = 1'b0;
        fill_rand();
        send_block(8'h80);
        t = 0;
        while (!m_valid && t < 100) begin @(posedge clk); #1; t++; end
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        ntot++; if (oq.size() !== 32) $display("FAIL mid_beats_before_reset: got %0d words, required 32", oq.size()); else npass++;
        @(posedge clk); #1;
        ntot++; if (m_valid !== 1'b0) $display("FAIL mid_rst_m_valid: got %b, required 0", m_valid); else npass++;
        ntot++; if (s_ready !== 1'b0) $display("FAIL mid_rst_s_ready: got %b, required 0", s_ready); else npass++;
        ntot++; if (core_out_ready !== 1'b0) $display("FAIL mid_rst_core_out_ready: got %b, required 0", core_out_ready); else npass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_q();
        m_ready = 1'b1;
        fill_rand();
        expect_block(1'b0);
        send_block(8'h80);
        wait_out(64);
        for (int i = 0; i < 64; i++) begin
            ntot++;
            if (oq[i] !== exp_q[i]) $display("FAIL mid_fresh_word[%0d]: got %0h, required %0h", i, oq[i], exp_q[i]);
            else npass++;
        end
        repeat (4) @(posedge clk);
        #1;
        ntot++; if (oq.size() !== 64) $display("FAIL mid_fresh_count: got %0d words, required 64", oq.size()); else npass++;
    endtask

    task automatic test_lanes();
        bit ok;
        int t;
        a_zz = 1'b1; b_zz = 1'b1;
        a_m_ready = 1'b1; b_m_ready = 1'b1;
        fill_rand();
        for (int b = 0; b < 64; b++) begin
            a_s_valid = 1'b1;
            a_s_data  = cur[b];
            a_s_last  = (b == 63);
            ok = 1'b0;
            for (int n = 0; n < 300 && !ok; n++) begin
                @(negedge clk); ok = a_s_ready;
                @(posedge clk); #1;
            end
            if (!ok) begin
                ntot++;
                $display("FAIL l1_send beat %0d: s_ready got 0, required 1", b);
                break;
            end
        end
        a_s_valid = 1'b0;
        for (int k = 0; k < 64; k++) b_s_data[k*DW +: DW] = cur[k];
        b_s_valid = 1'b1;
        b_s_last  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk); ok = b_s_ready;
            @(posedge clk); #1;
        end
        b_s_valid = 1'b0;
        ntot++; if (ok !== 1'b1) $display("FAIL l64_send: s_ready got 0, required 1"); else npass++;
        t = 0;
        while ((qa.size() < 64 || qb.size() < 64) && t < 500) begin @(posedge clk); #1; t++; end
        ntot++; if (qa.size() !== 64) $display("FAIL l1_beats: got %0d, required 64", qa.size()); else npass++;
        ntot++; if (qb.size() !== 64) $display("FAIL l64_words: got %0d, required 64", qb.size()); else npass++;
        ntot++; if (lb.size() !== 1) $display("FAIL l64_beats: got %0d, required 1", lb.size()); else npass++;
        ntot++; if (lb[0] !== 1'b1) $display("FAIL l64_m_last: got %b, required 1", lb[0]); else npass++;
        for (int i = 0; i < 64; i++) begin
            ntot++;
            if (qa[i] !== cur[zz_pos(i)]) $display("FAIL l1_word[%0d]: got %0h, required %0h", i, qa[i], cur[zz_pos(i)]);
            else npass++;
            ntot++;
            if (la[i] !== (i == 63)) $display("FAIL l1_m_last[%0d]: got %b, required %b", i, la[i], (i == 63));
            else npass++;
            ntot++;
            if (qb[i] !== cur[zz_pos(i)]) $display("FAIL l64_word[%0d]: got %0h, required %0h", i, qb[i], cur[zz_pos(i)]);
            else npass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        m_ready = 1'b0; zz_en = 1'b0;
        a_s_valid = 1'b0; a_s_last = 1'b0; a_s_data = '0; a_m_ready = 1'b0; a_zz = 1'b0;
        b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = '0; b_m_ready = 1'b0; b_zz = 1'b0;
        test_reset();
        test_raster();
        test_zigzag();
        test_back_to_back();
        test_framing();
        test_reset_mid_drain();
        test_lanes();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
